// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory with valid/ready request and response
// channels, a one-entry registered response, and range/alignment/mode error reporting.
module data_mem_ctrl #(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_wmode,
  input  logic [2:0]              req_rmode,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;
  localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
  localparam int unsigned SZ_W   = $clog2(DATA_BYTES) + 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state;
  logic                accept;
  logic                wr;
  logic [SZ_W-1:0]     size;
  logic                illegal;
  logic                sgn;
  logic                misalign;
  logic                err_c;
  logic                top_bit;
  logic [ADDR_WIDTH:0] end_addr;
  logic [IDX_W-1:0]    idx [DATA_BYTES];
  logic [DATA_W-1:0]   load;
  logic [DATA_W-1:0]   rdata_c;
  logic [7:0]          mem [DEPTH_BYTES];

  assign rsp_valid = (state == FULL);
  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign wr        = (req_wmode != 2'b00);

  // Access size and signedness from the mode fields
  always_comb begin
    size    = SZ_W'(DATA_BYTES);
    illegal = 1'b0;
    sgn     = 1'b0;
    if (wr) begin
      case (req_wmode)
        2'b10:   size = SZ_W'(2);
        2'b11:   size = SZ_W'(1);
        default: size = SZ_W'(DATA_BYTES);
      endcase
    end else begin
      case (req_rmode)
        3'b000:  size = SZ_W'(DATA_BYTES);
        3'b001:  size = SZ_W'(2);
        3'b011: begin
          size = SZ_W'(2);
          sgn  = 1'b1;
        end
        3'b010:  size = SZ_W'(1);
        3'b110: begin
          size = SZ_W'(1);
          sgn  = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Range check is one bit wider than the address so the end cannot wrap to a small value
  always_comb begin
    end_addr = {1'b0, req_addr} + (ADDR_WIDTH + 1)'(size);
    misalign = ALIGN_CHECK && ((req_addr[SZ_W-1:0] & (size - SZ_W'(1))) != '0);
    err_c    = illegal | (end_addr > (ADDR_WIDTH + 1)'(DEPTH_BYTES)) | misalign;
  end

  // Gather the addressed bytes and extend above the access size
  always_comb begin
    load    = '0;
    top_bit = 1'b0;
    rdata_c = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      idx[i] = req_addr[IDX_W-1:0] + IDX_W'(i);
      if (i < 32'(size)) begin
        load[8*i +: 8] = mem[idx[i]];
      end
      if (i == 32'(size) - 1) begin
        top_bit = load[8*i + 7];
      end
    end
    for (int unsigned b = 0; b < DATA_W; b++) begin
      rdata_c[b] = (b < 8 * 32'(size)) ? load[b] : (sgn & top_bit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      state     <= FULL;
      rsp_err   <= err_c;
      rsp_rdata <= (wr || err_c) ? '0 : rdata_c;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (accept && wr && !err_c && !rst) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        if (i < 32'(size)) begin
          mem[idx[i]] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl; two instances (alignment checked and
// unchecked) share stimulus and are compared every cycle against a byte-array model.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic [1:0] req_wmode;
  logic [2:0] req_rmode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_ready;
  logic [1:0] rdy;
  logic [1:0] vld;
  logic [1:0] err;
  logic [1:0][31:0] rdat;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .ALIGN_CHECK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_wmode(req_wmode),
    .req_rmode(req_rmode), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[1]),
    .rsp_ready(rsp_ready), .rsp_rdata(rdat[1]), .rsp_err(err[1]));

  data_mem_ctrl #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .ALIGN_CHECK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_wmode(req_wmode),
    .req_rmode(req_rmode), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[0]),
    .rsp_ready(rsp_ready), .rsp_rdata(rdat[0]), .rsp_err(err[0]));

  // Reference state: byte memory and the single pending response per instance
  logic [7:0]  mm [2][DEPTH];
  bit          exp_v [2];
  logic [31:0] exp_d [2];
  bit          exp_e [2];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int unsigned acc_size(input logic [1:0] wm, input logic [2:0] rm);
    if (wm == 2'd1) return 4;
    if (wm == 2'd2) return 2;
    if (wm == 2'd3) return 1;
    case (rm)
      3'b000:         return 4;
      3'b001, 3'b011: return 2;
      3'b010, 3'b110: return 1;
      default:        return 0;
    endcase
  endfunction

  task automatic model_accept(input int k, input bit align);
    int unsigned sz;
    longint unsigned a;
    bit e;
    logic [31:0] v;
    sz = acc_size(req_wmode, req_rmode);
    a  = 64'(req_addr);
    e  = (sz == 0);
    if (!e) e = (a + 64'(sz) > 64'(DEPTH)) || (align && (a % 64'(sz) != 0));
    v = '0;
    if (!e && req_wmode != 2'b00) begin
      for (int b = 0; b < int'(sz); b++) mm[k][int'(a) + b] = req_wdata[8*b +: 8];
    end else if (!e) begin
      for (int b = 0; b < int'(sz); b++) v |= 32'(mm[k][int'(a) + b]) << (8 * b);
      if ((req_rmode == 3'b011 || req_rmode == 3'b110) && v[8*sz - 1])
        v |= ~((32'd1 << (8 * sz)) - 32'd1);
    end
    exp_v[k] = 1'b1;
    exp_d[k] = v;
    exp_e[k] = e;
  endtask

  // Compare both instances against the model, then advance the model over the coming edge
  task automatic check_and_predict();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d.req_ready", k), 32'(rdy[k]), 32'(!exp_v[k] || rsp_ready));
      chk($sformatf("dut%0d.rsp_valid", k), 32'(vld[k]), 32'(exp_v[k]));
      if (exp_v[k]) begin
        chk($sformatf("dut%0d.rsp_rdata", k), rdat[k], exp_d[k]);
        chk($sformatf("dut%0d.rsp_err", k), 32'(err[k]), 32'(exp_e[k]));
      end
      if (req_valid && (!exp_v[k] || rsp_ready)) model_accept(k, k == 1);
      else if (rsp_ready) exp_v[k] = 1'b0;
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] wm, input logic [2:0] rm,
                       input logic [31:0] a, input logic [31:0] wd, input bit rr);
    @(negedge clk);
    req_valid = v;
    req_wmode = wm;
    req_rmode = rm;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = rr;
    #1;
    check_and_predict();
  endtask

  // One request, then an idle cycle showing its response; literal expectations on dut1
  task automatic lit(input string name, input logic [1:0] wm, input logic [2:0] rm,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] want_d, input bit want_e);
    cycle(1'b1, wm, rm, a, wd, 1'b1);
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);
    chk({name, ".valid"}, 32'(vld[1]), 32'd1);
    chk({name, ".rdata"}, rdat[1], want_d);
    chk({name, ".err"}, 32'(err[1]), 32'(want_e));
  endtask

  logic [31:0] held_d;
  int unsigned sel;
  logic [31:0] ra;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wmode = 2'b00;
    req_rmode = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    exp_v[0]  = 1'b0;
    exp_v[1]  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.valid", 32'(vld[1]), 32'd0);
    chk("reset.rdata", rdat[1], 32'h0);
    chk("reset.err", 32'(err[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.ready", 32'(rdy[1]), 32'd1);

    // Fill memory so every later read has a defined value
    for (int w = 0; w < int'(DEPTH / 4); w++) cycle(1'b1, 2'b01, 3'b000, 32'(4 * w), $urandom, 1'b1);
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);

    lit("wr_word", 2'b01, 3'b000, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0);
    lit("rd_word", 2'b00, 3'b000, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0);
    lit("rd_byte_u", 2'b00, 3'b010, 32'h10, 32'h0, 32'h000000D4, 1'b0);
    lit("rd_byte_s", 2'b00, 3'b110, 32'h10, 32'h0, 32'hFFFFFFD4, 1'b0);
    lit("rd_half_u", 2'b00, 3'b001, 32'h10, 32'h0, 32'h0000C3D4, 1'b0);
    lit("rd_half_s", 2'b00, 3'b011, 32'h12, 32'h0, 32'hFFFFA1B2, 1'b0);
    lit("wr_word_misal", 2'b01, 3'b000, 32'h11, 32'h11223344, 32'h0, 1'b1);
    chk("noalign.wr_word_misal.err", 32'(err[0]), 32'd0);
    lit("rd_after_misal", 2'b00, 3'b000, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0);
    lit("wr_half_misal", 2'b10, 3'b000, 32'h13, 32'h9999, 32'h0, 1'b1);
    lit("wr_byte_13", 2'b11, 3'b000, 32'h13, 32'hFFFFFF55, 32'h0, 1'b0);
    lit("rd_after_byte", 2'b00, 3'b000, 32'h10, 32'h0, 32'h55B2C3D4, 1'b0);
    lit("rd_word_top", 2'b00, 3'b000, 32'(DEPTH - 2), 32'h0, 32'h0, 1'b1);
    lit("wr_byte_last", 2'b11, 3'b000, 32'(DEPTH - 1), 32'h7E, 32'h0, 1'b0);
    lit("rd_byte_last", 2'b00, 3'b110, 32'(DEPTH - 1), 32'h0, 32'h0000007E, 1'b0);
    lit("rd_addr_max", 2'b00, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);
    lit("rd_bad_mode", 2'b00, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);

    // Backpressure: response held while rsp_ready is low, then back-to-back traffic
    cycle(1'b1, 2'b00, 3'b000, 32'h10, 32'h0, 1'b1);
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0);
    held_d = rdat[1];
    chk("hold.first", held_d, 32'h55B2C3D4);
    cycle(1'b1, 2'b00, 3'b000, 32'h20, 32'h0, 1'b0);
    chk("hold.ready", 32'(rdy[1]), 32'd0);
    chk("hold.rdata", rdat[1], held_d);
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("hold.rdata2", rdat[1], held_d);
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'b00, 3'b000, 32'(4 * i), 32'h0, 1'b1);
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);

    // Reset while a response is pending
    cycle(1'b1, 2'b01, 3'b000, 32'h20, 32'hCAFEF00D, 1'b1);
    cycle(1'b1, 2'b00, 3'b000, 32'h20, 32'h0, 1'b1);
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst%0d.valid", k), 32'(vld[k]), 32'd0);
      chk($sformatf("midrst%0d.rdata", k), rdat[k], 32'h0);
      chk($sformatf("midrst%0d.err", k), 32'(err[k]), 32'd0);
      exp_v[k] = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_wmode = 2'b01;
    req_addr  = 32'h20;
    req_wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("postrst.ready", 32'(rdy[1]), 32'd1);
    lit("postrst.rd", 2'b00, 3'b000, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom % 8;
      if (sel < 6) ra = 32'($urandom % DEPTH);
      else if (sel == 6) ra = 32'(DEPTH - 4 + ($urandom % 8));
      else ra = $urandom;
      cycle(($urandom % 4) != 0, 2'($urandom), 3'($urandom), ra, $urandom, ($urandom % 4) != 0);
    end
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
